fetch_sequencer: RTL
====================

# fetch_sequencer

- Sequences the program counter of the small in-order core: start, run, stall, branch, call/return and halt.
- Sits between the instruction decoder and instruction memory.
- Owns the PC register and a run-state FSM, and produces the fetch address with a valid strobe each cycle.
- Optionally includes a return-address stack (RAS) for single-level-per-entry call/return.

## Interface
- PC_W, 7: program counter width; address space is 2^PC_W instructions.
- START_PC, 0: PC value loaded on reset and on every start.
- RAS_DEPTH, 4: return-address stack entries, ≥1; used only when RAS is compiled in.

- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin execution from START_PC; honoured in IDLE and DONE only.
- stall  in  1  hold PC this cycle; level-sensitive.
- halt  in  1  decoded halt at current PC.
- branch  in  1  decoded branch at current PC.
- branch_conditional  in  1  branch is taken only if zero=1.
- zero  in  1  ALU zero flag.
- call  in  1  decoded call at current PC.
- ret  in  1  decoded return at current PC.
- target  in  PC_W  branch/call destination.
- PC  out  PC_W  current fetch address.
- fetch_valid  out  1  PC is being fetched this cycle.
- running  out  1  FSM in RUN.
- done  out  1  FSM in DONE.
- ras_err  out  1  sticky RAS overflow/underflow flag.

## Operation
- States: IDLE, RUN, DONE, FAULT.
- Reset values: state IDLE, PC=START_PC, RAS empty (depth count 0), fetch_valid=0, running=0, done=0, ras_err=0.
- fetch_valid = (state==RUN) && !stall. Decode inputs (halt, branch, call, ret) are ignored whenever fetch_valid=0.
- IDLE: PC held at START_PC. start → RUN.
- RUN with fetch_valid=1: exactly one next-PC action, priority halt > ret > call > branch > increment.
  - halt: PC unchanged, → DONE.
  - ret: PC ← top of RAS, pop.
  - call: push PC+1, PC ← target.
  - taken branch, i.e. branch && (!branch_conditional || zero): PC ← target.
  - Not-taken branch or no control op: PC ← PC+1.
- RUN with stall=1: PC, RAS and state all held.
- Arithmetic: PC+1 wraps modulo 2^PC_W (all-ones → 0). The pushed return address wraps the same way.
- DONE: PC held at the halt address. start → PC ← START_PC, RAS cleared, → RUN.
- start is ignored in RUN and FAULT.
- RAS full + call: no push, PC ← target anyway, ras_err ← 1, → FAULT.
- RAS empty + ret: PC held, ras_err ← 1, → FAULT.
- FAULT: fetch_valid=0, PC held. Exits only via reset_n.
- Reset mid-operation: asynchronous return to all reset values on the same clock cycle; no pending action completes.

## Timing
- Next-PC logic is combinational from the decode inputs. PC updates on the next rising edge, so a taken branch/call/ret has 1-cycle latency.
- start in IDLE at edge n: running=1 and fetch_valid=1 (if stall=0) at PC=START_PC after edge n.
- halt sampled at edge n: done=1 after edge n. PC stays equal to the halt address.
- stall is combinational onto fetch_valid (same cycle). Release resumes fetching at the held PC with no bubble.
- ras_err and the FAULT state take effect after the offending edge.

## Configuration
- FETCH_SEQUENCER_RAS_EN defined: RAS of RAS_DEPTH entries is implemented; call/ret and the FAULT state behave as described above.
- FETCH_SEQUENCER_RAS_EN undefined:
  - No stack storage.
  - call acts as an unconditional branch to target (no push).
  - ret acts as a plain increment (PC+1).
  - FAULT is unreachable; ras_err is tied to 0.
  - RAS_DEPTH is ignored.

## Test plan
- Reset/start: assert reset_n=0 mid-RUN at PC=0x25 → PC=0x00, fetch_valid=0 immediately. Pulse start → fetch_valid=1, PC sequence 0,1,2,3.
- Branches:
  - PC=0x10, branch=1, branch_conditional=1, zero=0, target=0x40 → next PC 0x11.
  - Same with zero=1 → next PC 0x40.
  - Unconditional branch → 0x40.
- Wrap/stall: run from 0x7E → 0x7F, 0x00. Hold stall=1 for 3 cycles at PC=0x05 → PC stays 0x05 and fetch_valid=0; branch asserted during stall is ignored.
- Call/return (RAS_EN, depth 4): call at 0x03 to 0x30, call at 0x31 to 0x50, ret, ret → PC 0x30, 0x50, 0x32, 0x04. A fifth nested call → ras_err=1, FAULT, fetch_valid=0.
- Halt/priority: halt+branch together at 0x12 → done=1, PC stays 0x12. start → PC=0x00, running=1, RAS empty (a following ret faults with RAS_EN, or increments to 0x01 without it).

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: start/run/stall/branch/call/return/halt with a run-state FSM.
// Optional return-address stack compiled in with FETCH_SEQUENCER_RAS_EN.
module fetch_sequencer #(
  parameter int unsigned PC_W      = 7,
  parameter int unsigned START_PC  = 0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch,
  input  logic            branch_conditional,
  input  logic            zero,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] PC,
  output logic            fetch_valid,
  output logic            running,
  output logic            done,
  output logic            ras_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] START = PC_W'(START_PC);

  if (RAS_DEPTH < 1) begin : g_depth_check
    $error("fetch_sequencer: RAS_DEPTH must be at least 1");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_fetch;
  logic            w_taken;

  assign w_fetch  = (r_state == S_RUN) && !stall;
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_taken  = branch && (!branch_conditional || zero);

`ifdef FETCH_SEQUENCER_RAS_EN
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << IDX_W;

  logic [PC_W-1:0]  r_ras [0:SLOTS-1];
  logic [CNT_W-1:0] r_ras_cnt;
  logic             r_ras_err;
  logic             w_push;
  logic             w_pop;
  logic             w_clr;
  logic             w_err_set;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_push_idx;

  assign w_ras_empty = (r_ras_cnt == '0);
  assign w_ras_full  = (r_ras_cnt == CNT_W'(RAS_DEPTH));
  assign w_top_idx   = IDX_W'(r_ras_cnt - CNT_W'(1));
  assign w_push_idx  = IDX_W'(r_ras_cnt);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
`ifdef FETCH_SEQUENCER_RAS_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    w_err_set   = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_pc_nxt = START;
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // One action per fetched cycle: halt > ret > call > branch > increment.
        if (w_fetch) begin
          if (halt) begin
            w_state_nxt = S_DONE;
          end else if (ret) begin
`ifdef FETCH_SEQUENCER_RAS_EN
            if (w_ras_empty) begin
              w_err_set   = 1'b1;
              w_state_nxt = S_FAULT;
            end else begin
              w_pop    = 1'b1;
              w_pc_nxt = r_ras[w_top_idx];
            end
`else
            w_pc_nxt = w_pc_inc;
`endif
          end else if (call) begin
            w_pc_nxt = target;
`ifdef FETCH_SEQUENCER_RAS_EN
            if (w_ras_full) begin
              w_err_set   = 1'b1;
              w_state_nxt = S_FAULT;
            end else begin
              w_push = 1'b1;
            end
`endif
          end else if (w_taken) begin
            w_pc_nxt = target;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          w_pc_nxt    = START;
          w_state_nxt = S_RUN;
`ifdef FETCH_SEQUENCER_RAS_EN
          w_clr       = 1'b1;
`endif
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= START;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

`ifdef FETCH_SEQUENCER_RAS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ras_cnt <= '0;
      r_ras_err <= 1'b0;
      for (int unsigned i = 0; i < SLOTS; i++) r_ras[i] <= '0;
    end else begin
      if (w_err_set) r_ras_err <= 1'b1;
      if (w_clr) begin
        r_ras_cnt <= '0;
      end else if (w_push) begin
        r_ras[w_push_idx] <= w_pc_inc;
        r_ras_cnt         <= r_ras_cnt + CNT_W'(1);
      end else if (w_pop) begin
        r_ras_cnt <= r_ras_cnt - CNT_W'(1);
      end
    end
  end

  assign ras_err = r_ras_err;
`else
  assign ras_err = 1'b0;
`endif

  assign PC          = r_pc;
  assign fetch_valid = w_fetch;
  assign running     = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);

endmodule
